// File: rtl/hms_clock_core.sv
// hms_clock_core: hour/minute/second timekeeping core with a switch debouncer,
// a setup-mode controller and a blink mask for the display chain.
// Everything runs on clk; the seconds, debounce and blink rates are clock enables.
module hms_clock_core #(
  parameter int TICK_DIV  = 50000000,
  parameter int DEB_DIV   = 500000,
  parameter int BLINK_DIV = 25000000,
  parameter int HOUR12    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic [2:0] o_blank,
  output logic       o_day_tick
);

  localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DEB_W   = (DEB_DIV   > 1) ? $clog2(DEB_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  localparam logic [4:0] HOUR_RESET = (HOUR12 != 0) ? 5'd12 : 5'd0;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_t;

  mode_t mode_q, mode_d;

  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_strobe, deb_strobe_q;
  logic [2:0]         sw_s1, sw_s2, sw_ev;
  logic [TICK_W-1:0]  tick_cnt;
  logic               sec_tick;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [5:0]         sec_q, sec_d, min_q, min_d;
  logic [4:0]         hour_q, hour_d, hour_inc;
  logic               pm_q, pm_d, pm_inc, hour_wrap;
  logic [1:0]         pos_q, pos_d;
  logic [2:0]         blank_q, blank_d;
  logic               day_q, day_d;

  assign deb_strobe = (deb_cnt == DEB_MAX);
  assign sw_ev      = {3{deb_strobe_q}} & sw_s2 & ~sw_s1;
  assign sec_tick   = (mode_q == CLOCK) && (tick_cnt == TICK_MAX);

  // Sample the raw switches on the debounce strobe; a press is a released-then-pressed pair of samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt      <= '0;
      deb_strobe_q <= 1'b0;
      sw_s1        <= 3'b111;
      sw_s2        <= 3'b111;
    end else begin
      deb_strobe_q <= deb_strobe;
      if (deb_strobe) begin
        deb_cnt <= '0;
        sw_s1   <= {i_sw2, i_sw1, i_sw0};
        sw_s2   <= sw_s1;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Seconds prescaler runs only while keeping time so leaving setup restarts a full second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (mode_q == SETUP || sec_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Next hour value shared by timekeeping carry and setup increment, with the 12 h PM handling
  always_comb begin
    hour_inc  = hour_q + 5'd1;
    pm_inc    = pm_q;
    hour_wrap = 1'b0;
    if (HOUR12 != 0) begin
      if (hour_q == 5'd12) begin
        hour_inc = 5'd1;
      end else if (hour_q == 5'd11) begin
        pm_inc    = ~pm_q;
        hour_wrap = pm_q;
      end
    end else if (hour_q == 5'd23) begin
      hour_inc  = 5'd0;
      hour_wrap = 1'b1;
    end
  end

  // Mode FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= CLOCK;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode transitions, time counting, setup edits and the blink mask for the next cycle
  always_comb begin
    mode_d      = mode_q;
    pos_d       = pos_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    pm_d        = pm_q;
    day_d       = 1'b0;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    blank_d     = 3'b000;
    case (mode_q)
      CLOCK: begin
        if (sec_tick) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = hour_inc;
              pm_d   = pm_inc;
              day_d  = hour_wrap;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (sw_ev[0]) begin
          mode_d = SETUP;
          pos_d  = POS_SEC;
        end
      end
      default: begin
        if (sw_ev[0]) begin
          mode_d = CLOCK;
        end else begin
          if (sw_ev[2]) begin
            case (pos_q)
              POS_SEC:  sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
              POS_MIN:  min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
              default: begin
                hour_d = hour_inc;
                pm_d   = pm_inc;
              end
            endcase
          end
          if (sw_ev[1]) begin
            case (pos_q)
              POS_SEC: pos_d = POS_MIN;
              POS_MIN: pos_d = POS_HOUR;
              default: pos_d = POS_SEC;
            endcase
          end
        end
      end
    endcase
    if (mode_q == SETUP && mode_d == SETUP) begin
      if (blink_cnt_q == BLINK_MAX) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
      end
    end
    if (mode_d == SETUP && phase_d) begin
      case (pos_d)
        POS_SEC:  blank_d = 3'b001;
        POS_MIN:  blank_d = 3'b010;
        default:  blank_d = 3'b100;
      endcase
    end
  end

  // Time, position, blink and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= HOUR_RESET;
      pm_q        <= 1'b0;
      pos_q       <= POS_SEC;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= 3'b000;
      day_q       <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      pos_q       <= pos_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
      day_q       <= day_d;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_pm       = pm_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_blank    = blank_q;
  assign o_day_tick = day_q;

endmodule

// File: tb/tb_hms_clock_core.sv
// tb_hms_clock_core: directed bench for hms_clock_core with a 24 h and a 12 h instance.
module tb_hms_clock_core;

  localparam int TICK_DIV  = 4;
  localparam int DEB_DIV   = 2;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst24_n, rst12_n;
  logic [2:0] sw24_n, sw12_n;

  logic [5:0] sec24, min24, sec12, min12;
  logic [4:0] hour24, hour12;
  logic       pm24, pm12, mode24, mode12, day24, day12;
  logic [1:0] pos24, pos12;
  logic [2:0] blank24, blank12;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int day24_cnt = 0;
  int day12_cnt = 0;
  int mode24_toggles = 0;
  logic mode24_prev = 1'b0;
  bit sel12 = 1'b0;
  int entry_cyc;
  int d0;
  int t0;
  int j;
  bit found;

  hms_clock_core #(.TICK_DIV(TICK_DIV), .DEB_DIV(DEB_DIV), .BLINK_DIV(BLINK_DIV), .HOUR12(0)) dut24 (
    .clk(clk), .rst_n(rst24_n), .i_sw0(sw24_n[0]), .i_sw1(sw24_n[1]), .i_sw2(sw24_n[2]),
    .o_sec(sec24), .o_min(min24), .o_hour(hour24), .o_pm(pm24), .o_mode(mode24),
    .o_position(pos24), .o_blank(blank24), .o_day_tick(day24)
  );

  hms_clock_core #(.TICK_DIV(TICK_DIV), .DEB_DIV(DEB_DIV), .BLINK_DIV(BLINK_DIV), .HOUR12(1)) dut12 (
    .clk(clk), .rst_n(rst12_n), .i_sw0(sw12_n[0]), .i_sw1(sw12_n[1]), .i_sw2(sw12_n[2]),
    .o_sec(sec12), .o_min(min12), .o_hour(hour12), .o_pm(pm12), .o_mode(mode12),
    .o_position(pos12), .o_blank(blank12), .o_day_tick(day12)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used as the time base for blink expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Count day-tick cycles and mode changes seen on each falling edge
  always @(negedge clk) begin
    if (day24) day24_cnt = day24_cnt + 1;
    if (day12) day12_cnt = day12_cnt + 1;
    if (mode24 !== mode24_prev) mode24_toggles = mode24_toggles + 1;
    mode24_prev = mode24;
  end

  // Overall time limit so the bench can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_sw(input logic [2:0] v);
    if (sel12) sw12_n = v;
    else       sw24_n = v;
  endtask

  task automatic applyReset();
    drive_sw(3'b111);
    if (sel12) rst12_n = 1'b0;
    else       rst24_n = 1'b0;
    step(2);
    if (sel12) rst12_n = 1'b1;
    else       rst24_n = 1'b1;
  endtask

  task automatic releaseAll();
    drive_sw(3'b111);
    step(6);
  endtask

  // One debounced press of every switch in mask ({sw2,sw1,sw0}), then release
  task automatic applyStimulus(input logic [2:0] mask);
    drive_sw(~mask);
    step(6);
    releaseAll();
  endtask

  task automatic applyPresses(input logic [2:0] mask, input int n);
    for (int i = 0; i < n; i++) applyStimulus(mask);
  endtask

  // Press mask and return at the first sample where the mode equals want; switches stay pressed
  task automatic toggleMode(input logic [2:0] mask, input logic want, input string tag);
    bit seen;
    seen = 1'b0;
    drive_sw(~mask);
    for (int i = 0; i < 16 && !seen; i++) begin
      step(1);
      if ((sel12 ? mode12 : mode24) == want) seen = 1'b1;
    end
    checkOutput(tag, seen, 1);
  endtask

  initial begin
    rst24_n = 1'b0;
    rst12_n = 1'b0;
    sw24_n  = 3'b111;
    sw12_n  = 3'b111;
    step(2);

    // Reset state of both instances
    checkOutput("rst_sec", sec24, 0);
    checkOutput("rst_min", min24, 0);
    checkOutput("rst_hour", hour24, 0);
    checkOutput("rst_pm", pm24, 0);
    checkOutput("rst_mode", mode24, 0);
    checkOutput("rst_pos", pos24, 0);
    checkOutput("rst_blank", blank24, 0);
    checkOutput("rst_day", day24, 0);
    checkOutput("rst12_hour", hour12, 12);
    checkOutput("rst12_pm", pm12, 0);

    // Free run: tick every 4 cycles, 240 cycles gives one minute
    rst24_n = 1'b1;
    step(3);
    checkOutput("tick_edge3", sec24, 0);
    step(1);
    checkOutput("tick_edge4", sec24, 1);
    step(3);
    checkOutput("tick_edge7", sec24, 1);
    step(1);
    checkOutput("tick_edge8", sec24, 2);
    step(232);
    checkOutput("run240_sec", sec24, 0);
    checkOutput("run240_min", min24, 1);
    checkOutput("run240_hour", hour24, 0);

    // 24 h preload 23:59:59 then roll over the day
    applyReset();
    toggleMode(3'b001, 1'b1, "wrap_enter");
    checkOutput("wrap_enter_sec", sec24, 0);
    releaseAll();
    applyPresses(3'b100, 59);
    applyStimulus(3'b010);
    applyPresses(3'b100, 59);
    applyStimulus(3'b010);
    applyPresses(3'b100, 23);
    checkOutput("pre_hour", hour24, 23);
    checkOutput("pre_min", min24, 59);
    checkOutput("pre_sec", sec24, 59);
    checkOutput("pre_pos", pos24, 2);
    d0 = day24_cnt;
    toggleMode(3'b001, 1'b0, "wrap_leave");
    drive_sw(3'b111);
    step(3);
    checkOutput("hold_sec", sec24, 59);
    checkOutput("hold_hour", hour24, 23);
    step(1);
    checkOutput("roll_sec", sec24, 0);
    checkOutput("roll_min", min24, 0);
    checkOutput("roll_hour", hour24, 0);
    checkOutput("roll_day", day24, 1);
    step(1);
    checkOutput("roll_day_next", day24, 0);
    checkOutput("roll_day_count", day24_cnt - d0, 1);
    checkOutput("roll_pm24", pm24, 0);

    // Glitchy held mode switch gives exactly one toggle and freezes time
    applyReset();
    t0 = mode24_toggles;
    drive_sw(3'b110);
    step(1);
    drive_sw(3'b111);
    step(1);
    drive_sw(3'b110);
    step(48);
    checkOutput("glitch_mode", mode24, 1);
    checkOutput("glitch_toggles", mode24_toggles - t0, 1);
    checkOutput("glitch_pos", pos24, 0);
    checkOutput("glitch_sec", sec24, 1);
    releaseAll();

    // Setup increment of minutes wraps without carry
    applyReset();
    toggleMode(3'b001, 1'b1, "inc_enter");
    releaseAll();
    applyPresses(3'b100, 30);
    applyStimulus(3'b010);
    applyPresses(3'b100, 59);
    checkOutput("inc_pre_min", min24, 59);
    checkOutput("inc_pre_sec", sec24, 30);
    checkOutput("inc_pre_pos", pos24, 1);
    d0 = day24_cnt;
    applyStimulus(3'b100);
    checkOutput("inc_min", min24, 0);
    checkOutput("inc_sec", sec24, 30);
    checkOutput("inc_hour", hour24, 0);
    checkOutput("inc_no_day", day24_cnt - d0, 0);

    // Simultaneous sw1+sw2 then sw0+sw2
    applyPresses(3'b010, 2);
    checkOutput("sim_pos_sec", pos24, 0);
    applyStimulus(3'b110);
    checkOutput("sim12_sec", sec24, 31);
    checkOutput("sim12_pos", pos24, 1);
    checkOutput("sim12_min", min24, 0);
    toggleMode(3'b101, 1'b0, "sim02_mode");
    checkOutput("sim02_min", min24, 0);
    checkOutput("sim02_sec", sec24, 31);
    releaseAll();

    // Blink on the hour field, then steady after leaving setup
    applyReset();
    toggleMode(3'b001, 1'b1, "blink_enter");
    entry_cyc = cyc;
    checkOutput("blink_entry", blank24, 0);
    releaseAll();
    applyPresses(3'b010, 2);
    checkOutput("blink_pos", pos24, 2);
    for (int k = 0; k < 32; k++) begin
      step(1);
      j = cyc - entry_cyc;
      checkOutput("blink_phase", blank24, (((j / BLINK_DIV) % 2) == 1) ? 4 : 0);
    end
    toggleMode(3'b001, 1'b0, "blink_leave");
    drive_sw(3'b111);
    for (int k = 0; k < 20; k++) begin
      checkOutput("blink_off", blank24, 0);
      step(1);
    end

    // Asynchronous reset in the middle of a blink
    applyReset();
    toggleMode(3'b001, 1'b1, "arst_enter");
    releaseAll();
    applyPresses(3'b010, 2);
    applyStimulus(3'b100);
    checkOutput("arst_pre_hour", hour24, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (blank24 == 3'b100) found = 1'b1;
      else step(1);
    end
    checkOutput("arst_blink_seen", found, 1);
    #2;
    rst24_n = 1'b0;
    #1;
    checkOutput("arst_hour", hour24, 0);
    checkOutput("arst_mode", mode24, 0);
    checkOutput("arst_pos", pos24, 0);
    checkOutput("arst_blank", blank24, 0);
    checkOutput("arst_sec", sec24, 0);
    step(1);
    rst24_n = 1'b1;

    // 12 h: 11:59:59 PM rolls to 12:00:00 AM with a day tick
    sel12 = 1'b1;
    applyReset();
    toggleMode(3'b001, 1'b1, "h12_enter");
    releaseAll();
    applyPresses(3'b100, 59);
    applyStimulus(3'b010);
    applyPresses(3'b100, 59);
    applyStimulus(3'b010);
    applyPresses(3'b100, 11);
    checkOutput("h12_set11_hour", hour12, 11);
    checkOutput("h12_set11_pm", pm12, 0);
    applyStimulus(3'b100);
    checkOutput("h12_set12_hour", hour12, 12);
    checkOutput("h12_set12_pm", pm12, 1);
    applyPresses(3'b100, 11);
    checkOutput("h12_pre_hour", hour12, 11);
    checkOutput("h12_pre_pm", pm12, 1);
    d0 = day12_cnt;
    toggleMode(3'b001, 1'b0, "h12_leave");
    drive_sw(3'b111);
    step(3);
    checkOutput("h12_hold_sec", sec12, 59);
    step(1);
    checkOutput("h12_roll_hour", hour12, 12);
    checkOutput("h12_roll_min", min12, 0);
    checkOutput("h12_roll_sec", sec12, 0);
    checkOutput("h12_roll_pm", pm12, 0);
    checkOutput("h12_roll_day", day12, 1);
    step(1);
    checkOutput("h12_day_next", day12, 0);
    checkOutput("h12_day_count", day12_cnt - d0, 1);

    // 12 h: 12:59:59 rolls to 1:00:00 with PM unchanged and no day tick
    applyReset();
    toggleMode(3'b001, 1'b1, "h12b_enter");
    releaseAll();
    applyPresses(3'b100, 59);
    applyStimulus(3'b010);
    applyPresses(3'b100, 59);
    d0 = day12_cnt;
    toggleMode(3'b001, 1'b0, "h12b_leave");
    drive_sw(3'b111);
    step(4);
    checkOutput("h12b_hour", hour12, 1);
    checkOutput("h12b_min", min12, 0);
    checkOutput("h12b_sec", sec12, 0);
    checkOutput("h12b_pm", pm12, 0);
    step(1);
    checkOutput("h12b_no_day", day12_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
